// File: rtl/alu_mul_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_mul_sequencer_pkg
// Description : Shared constants, FSM state type and flag helper for the
//               multi-cycle MUL sequencer that borrows the EXE-stage ALU.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_mul_sequencer_pkg;

  // Datapath width shared with the rest of the core
  localparam int WORD_WIDTH = 32;

  // ALU command encoding used by the sequencer while it owns the ALU
  localparam logic [3:0] EX_ADD = 4'b0010;

  // Sequencer state encodings (2-bit)
  localparam logic [1:0] MUL_IDLE = 2'd0;
  localparam logic [1:0] MUL_RUN  = 2'd1;
  localparam logic [1:0] MUL_DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = MUL_IDLE,
    ST_RUN  = MUL_RUN,
    ST_DONE = MUL_DONE
  } mul_state_e;

  // ARM MUL-style flags {Z,C,N,V}: Z and N from the product, C and V kept
  function automatic logic [3:0] mul_flags(input logic is_zero,
                                           input logic is_neg,
                                           input logic [3:0] sr);
    return {is_zero, sr[2], is_neg, sr[0]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_mul_sequencer_alu_port_mux.sv
`default_nettype none
// ============================================================================
// Module      : alu_port_mux
// Description : 2:1 selector for the ALU command/operand/carry bundle. The
//               pipeline owns the ALU unless the multiplier is iterating.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_port_mux #(
  parameter int WIDTH = 32
) (
  input  logic             sel,
  input  logic [3:0]       pipe_cmd,
  input  logic [WIDTH-1:0] pipe_val1,
  input  logic [WIDTH-1:0] pipe_val2,
  input  logic             pipe_carry,
  input  logic [3:0]       mul_cmd,
  input  logic [WIDTH-1:0] mul_val1,
  input  logic [WIDTH-1:0] mul_val2,
  input  logic             mul_carry,
  output logic [3:0]       out_cmd,
  output logic [WIDTH-1:0] out_val1,
  output logic [WIDTH-1:0] out_val2,
  output logic             out_carry
);

  // sel=1 hands the ALU to the multiplier, otherwise pure pass-through
  always_comb begin
    out_cmd   = pipe_cmd;
    out_val1  = pipe_val1;
    out_val2  = pipe_val2;
    out_carry = pipe_carry;
    if (sel) begin
      out_cmd   = mul_cmd;
      out_val1  = mul_val1;
      out_val2  = mul_val2;
      out_carry = mul_carry;
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_mul_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_mul_sequencer
// Description : Multi-cycle shift-add 32x32->32 multiplier that time-shares
//               the single EXE-stage ALU, stalling the pipeline while it runs.
//               Returns the product low word and optional N/Z flags.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_mul_sequencer
  import alu_mul_sequencer_pkg::*;
#(
  parameter int WORD_WIDTH = alu_mul_sequencer_pkg::WORD_WIDTH,
  parameter bit EARLY_OUT  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mul_start,
  input  logic                  mul_s,
  input  logic [WORD_WIDTH-1:0] mul_rm,
  input  logic [WORD_WIDTH-1:0] mul_rs,
  input  logic [3:0]            cur_sr,
  input  logic [3:0]            pipe_exe_cmd,
  input  logic [WORD_WIDTH-1:0] pipe_val1,
  input  logic [WORD_WIDTH-1:0] pipe_val2,
  input  logic                  pipe_carry,
  input  logic [WORD_WIDTH-1:0] alu_result,
  output logic [3:0]            alu_exe_cmd,
  output logic [WORD_WIDTH-1:0] alu_val1,
  output logic [WORD_WIDTH-1:0] alu_val2,
  output logic                  alu_carry,
  output logic                  busy,
  output logic                  stall,
  output logic                  mul_done,
  output logic [WORD_WIDTH-1:0] mul_result,
  output logic                  mul_sr_wr,
  output logic [3:0]            mul_sr
);

  localparam int CNT_W = $clog2(WORD_WIDTH);
  localparam logic [CNT_W-1:0] C_LAST_CNT = CNT_W'(WORD_WIDTH - 1);

  mul_state_e            r_state;
  mul_state_e            w_next_state;
  logic [WORD_WIDTH-1:0] r_acc;
  logic [WORD_WIDTH-1:0] r_mcand;
  logic [WORD_WIDTH-1:0] r_mplier;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_s;
  logic [WORD_WIDTH-1:0] r_mul_result;
  logic [3:0]            r_mul_sr;

  logic                  w_run;
  logic                  w_done;
  logic                  w_last_iter;
  logic [WORD_WIDTH-1:0] w_addend;
  logic [3:0]            w_flags;
  logic                  w_unused_sr;

  // Only C and V pass through from the status register
  assign w_unused_sr = ^{cur_sr[3], cur_sr[1]};

  assign w_run  = (r_state == ST_RUN);
  assign w_done = (r_state == ST_DONE);

  // Final iteration: full width reached, or no multiplier bits left to add
  assign w_last_iter = (r_cnt == C_LAST_CNT) ||
                       (EARLY_OUT && ((r_mplier >> 1) == '0));

  assign w_addend = r_mplier[0] ? r_mcand : '0;
  assign w_flags  = mul_flags((r_acc == '0), r_acc[WORD_WIDTH-1], cur_sr);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; a start request is only honoured from IDLE
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (mul_start) w_next_state = ST_RUN;
      ST_RUN:  if (w_last_iter) w_next_state = ST_DONE;
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Operand capture, shift-add iteration and result/flag holding registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc        <= '0;
      r_mcand      <= '0;
      r_mplier     <= '0;
      r_cnt        <= '0;
      r_s          <= 1'b0;
      r_mul_result <= '0;
      r_mul_sr     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (mul_start) begin
            r_mcand  <= mul_rm;
            r_mplier <= mul_rs;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_s      <= mul_s;
          end
        end
        ST_RUN: begin
          r_acc    <= alu_result;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 1'b1;
        end
        ST_DONE: begin
          r_mul_result <= r_acc;
          if (r_s) r_mul_sr <= w_flags;
        end
        default: ;
      endcase
    end
  end

  // ALU ownership: multiplier during RUN, pipeline otherwise
  alu_port_mux #(
    .WIDTH      (WORD_WIDTH)
  ) u_alu_port_mux (
    .sel        (w_run),
    .pipe_cmd   (pipe_exe_cmd),
    .pipe_val1  (pipe_val1),
    .pipe_val2  (pipe_val2),
    .pipe_carry (pipe_carry),
    .mul_cmd    (EX_ADD),
    .mul_val1   (r_acc),
    .mul_val2   (w_addend),
    .mul_carry  (1'b0),
    .out_cmd    (alu_exe_cmd),
    .out_val1   (alu_val1),
    .out_val2   (alu_val2),
    .out_carry  (alu_carry)
  );

  // Status and result outputs; the product is visible in DONE, then held
  always_comb begin
    busy       = (r_state != ST_IDLE);
    stall      = w_run;
    mul_done   = w_done;
    mul_sr_wr  = w_done && r_s;
    mul_result = w_done ? r_acc : r_mul_result;
    mul_sr     = (w_done && r_s) ? w_flags : r_mul_sr;
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_mul_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_mul_sequencer
// Description : Directed self-checking bench for alu_mul_sequencer with a
//               simple combinational ALU in the loop.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_mul_sequencer;
  import alu_mul_sequencer_pkg::*;

  localparam int W = 32;
  localparam logic [3:0] C_OTHER_CMD = 4'b0100;

  logic         clk = 1'b0;
  logic         rst;
  logic         mul_start, mul_s;
  logic [W-1:0] mul_rm, mul_rs;
  logic [3:0]   cur_sr;
  logic [3:0]   pipe_exe_cmd;
  logic [W-1:0] pipe_val1, pipe_val2;
  logic         pipe_carry;
  logic [W-1:0] alu_result;
  logic [3:0]   alu_exe_cmd;
  logic [W-1:0] alu_val1, alu_val2;
  logic         alu_carry;
  logic         busy, stall, mul_done, mul_sr_wr;
  logic [W-1:0] mul_result;
  logic [3:0]   mul_sr;

  int n_cmp = 0;
  int n_err = 0;
  int run_cycles;
  int dones;

  alu_mul_sequencer #(
    .WORD_WIDTH   (W),
    .EARLY_OUT    (1'b1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .mul_start    (mul_start),
    .mul_s        (mul_s),
    .mul_rm       (mul_rm),
    .mul_rs       (mul_rs),
    .cur_sr       (cur_sr),
    .pipe_exe_cmd (pipe_exe_cmd),
    .pipe_val1    (pipe_val1),
    .pipe_val2    (pipe_val2),
    .pipe_carry   (pipe_carry),
    .alu_result   (alu_result),
    .alu_exe_cmd  (alu_exe_cmd),
    .alu_val1     (alu_val1),
    .alu_val2     (alu_val2),
    .alu_carry    (alu_carry),
    .busy         (busy),
    .stall        (stall),
    .mul_done     (mul_done),
    .mul_result   (mul_result),
    .mul_sr_wr    (mul_sr_wr),
    .mul_sr       (mul_sr)
  );

  always #5 clk = ~clk;

  // Stand-in EXE ALU: add with carry for EX_ADD, XOR for anything else
  assign alu_result = (alu_exe_cmd == EX_ADD) ? (alu_val1 + alu_val2 + {{(W-1){1'b0}}, alu_carry})
                                              : (alu_val1 ^ alu_val2);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch a multiply and return in the DONE cycle; optionally re-pulse
  // mul_start and scramble the operands while it runs and in DONE
  task automatic run_mul(input logic [W-1:0] rm, input logic [W-1:0] rs,
                         input logic s, input logic disturb,
                         output int cycles, output int n_done);
    mul_rm = rm; mul_rs = rs; mul_s = s; mul_start = 1'b1;
    #1;
    check("start_cycle_pipe_owns_alu", alu_exe_cmd, C_OTHER_CMD);
    tick();
    mul_start = 1'b0;
    cycles = 0;
    n_done = 0;
    while (stall && cycles < 40) begin
      if (cycles == 0) begin
        check("run_cmd_add", alu_exe_cmd, EX_ADD);
        check("run_carry0", alu_carry, 1'b0);
      end
      if (disturb) begin
        mul_start = (cycles == 1);
        mul_rm = 32'hDEAD_BEEF;
        mul_rs = 32'h0000_0F0F;
        #1;
      end
      if (mul_done) n_done++;
      cycles++;
      tick();
    end
    if (disturb) begin
      mul_start = 1'b1;
      #1;
    end
    if (mul_done) n_done++;
  endtask

  initial begin
    rst = 1'b1; mul_start = 1'b0; mul_s = 1'b0; mul_rm = '0; mul_rs = '0;
    cur_sr = 4'b0101;
    pipe_exe_cmd = EX_ADD; pipe_val1 = 32'd5; pipe_val2 = 32'd3; pipe_carry = 1'b1;
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_stall", stall, 1'b0);
    check("rst_done", mul_done, 1'b0);
    check("rst_result", mul_result, 32'h0);
    check("rst_sr", mul_sr, 4'h0);
    check("rst_sr_wr", mul_sr_wr, 1'b0);
    tick();
    rst = 1'b0;
    #1;

    // IDLE pass-through
    check("pt_cmd", alu_exe_cmd, EX_ADD);
    check("pt_val1", alu_val1, 32'd5);
    check("pt_val2", alu_val2, 32'd3);
    check("pt_carry", alu_carry, 1'b1);
    check("pt_alu_result", alu_result, 32'd9);
    check("pt_busy", busy, 1'b0);
    check("pt_stall", stall, 1'b0);

    pipe_exe_cmd = C_OTHER_CMD; pipe_val1 = 32'hAAAA; pipe_val2 = 32'h5555; pipe_carry = 1'b1;

    // 7 * 6 = 42, no flag write, 3 RUN cycles
    run_mul(32'd7, 32'd6, 1'b0, 1'b0, run_cycles, dones);
    check("m1_run_cycles", run_cycles, 3);
    check("m1_done", mul_done, 1'b1);
    check("m1_busy_in_done", busy, 1'b1);
    check("m1_done_pipe_owns_alu", alu_exe_cmd, C_OTHER_CMD);
    check("m1_result", mul_result, 32'd42);
    check("m1_sr_wr", mul_sr_wr, 1'b0);
    tick();
    check("m1_done_pulse", mul_done, 1'b0);
    check("m1_busy_after", busy, 1'b0);
    check("m1_result_held", mul_result, 32'd42);

    // Zero multiplier: one RUN cycle, Z set, C/V kept from cur_sr
    run_mul(32'h1234, 32'h0, 1'b1, 1'b0, run_cycles, dones);
    check("m2_run_cycles", run_cycles, 1);
    check("m2_result", mul_result, 32'h0);
    check("m2_sr_wr", mul_sr_wr, 1'b1);
    check("m2_sr", mul_sr, 4'b1101);
    tick();
    check("m2_sr_held", mul_sr, 4'b1101);
    check("m2_sr_wr_pulse", mul_sr_wr, 1'b0);

    // Full-width: 0xFFFFFFFF^2 mod 2^32 = 1
    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, run_cycles, dones);
    check("m3_run_cycles", run_cycles, 32);
    check("m3_result", mul_result, 32'h1);
    tick();

    // Negative product: N=1, Z=0
    run_mul(32'hFFFF_FFFF, 32'd2, 1'b1, 1'b0, run_cycles, dones);
    check("m4_run_cycles", run_cycles, 2);
    check("m4_result", mul_result, 32'hFFFF_FFFE);
    check("m4_sr", mul_sr, 4'b0111);
    tick();

    // Re-start and operand changes during RUN/DONE are ignored: 5*9=45
    run_mul(32'd5, 32'd9, 1'b0, 1'b1, run_cycles, dones);
    check("m5_run_cycles", run_cycles, 4);
    check("m5_result", mul_result, 32'd45);
    tick();
    mul_start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (mul_done) dones++;
      tick();
    end
    check("m5_single_done", dones, 1);
    check("m5_idle_after", busy, 1'b0);
    check("m5_result_held", mul_result, 32'd45);

    // Reset in RUN cycle 10 of a full-width multiply
    mul_rm = 32'hFFFF_FFFF; mul_rs = 32'hFFFF_FFFF; mul_s = 1'b1; mul_start = 1'b1;
    tick();
    mul_start = 1'b0;
    dones = 0;
    for (int i = 0; i < 9; i++) begin
      if (mul_done) dones++;
      tick();
    end
    check("m6_running", stall, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("m6_rst_busy", busy, 1'b0);
    check("m6_rst_stall", stall, 1'b0);
    check("m6_rst_result", mul_result, 32'h0);
    check("m6_rst_pipe_owns_alu", alu_exe_cmd, C_OTHER_CMD);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (mul_done) dones++;
      tick();
    end
    check("m6_no_done", dones, 0);
    check("m6_idle", busy, 1'b0);
    check("m6_result_zero", mul_result, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
